// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the reduced RISC-V core (addi/add/bne).
// Walks the shared datapath through fetch, decode, execute/branch and writeback.
module multicycle_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  instr_valid,
    input  logic                  EQ,
    output logic                  instr_req,
    output logic                  IRWrite,
    output logic                  ALUsrc,
    output logic [2:0]            ALUctrl,
    output logic [1:0]            ImmSrc,
    output logic                  RegWrite,
    output logic                  PCWrite,
    output logic                  PCsrc,
    output logic [CNT_WIDTH-1:0]  retire_cnt,
    output logic                  trap
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WB, BRANCH, TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ADDI, C_ADD, C_BNE, C_ILLEGAL
    } class_t;

    state_t state, state_nxt;
    class_t cls, dec_class;

    logic unused_instr;
    assign unused_instr = ^instr;

    // The word is classified as it arrives and only the class is stored;
    // this is equivalent to decoding the latched instruction register.
    always_comb begin
        dec_class = C_ILLEGAL;
        if (instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000)
            dec_class = C_ADDI;
        else if (instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000 &&
                 instr[31:25] == 7'b0000000)
            dec_class = C_ADD;
        else if (instr[6:0] == 7'b1100011 && instr[14:12] == 3'b001)
            dec_class = C_BNE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cls        <= C_NONE;
            retire_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && instr_valid)
                cls <= dec_class;
            if (state == WB || state == BRANCH)
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (instr_valid) state_nxt = DECODE;
            DECODE: begin
                case (cls)
                    C_ADDI, C_ADD: state_nxt = EXEC;
                    C_BNE:         state_nxt = BRANCH;
                    default:       state_nxt = TRAP;
                endcase
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = FETCH;
            BRANCH:  state_nxt = FETCH;
            TRAP:    state_nxt = TRAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_req = 1'b0;
        IRWrite   = 1'b0;
        ALUsrc    = 1'b0;
        ALUctrl   = 3'b000;
        ImmSrc    = 2'b00;
        RegWrite  = 1'b0;
        PCWrite   = 1'b0;
        PCsrc     = 1'b0;
        trap      = 1'b0;
        case (state)
            FETCH: begin
                instr_req = 1'b1;
                IRWrite   = instr_valid;
            end
            DECODE:  ImmSrc = (cls == C_BNE) ? 2'b01 : 2'b00;
            EXEC:    ALUsrc = (cls == C_ADDI);
            WB: begin
                ALUsrc   = (cls == C_ADDI);
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
            end
            BRANCH: begin
                ALUctrl = 3'b001;
                ImmSrc  = 2'b01;
                PCWrite = 1'b1;
                PCsrc   = ~EQ;
            end
            TRAP:    trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus side queues each expected
// retirement, and a monitor checks it whenever the DUT pulses PCWrite.
module tb_multicycle_ctrl;

    localparam int CW = 4;
    localparam int K_ADDI = 0;
    localparam int K_ADD  = 1;
    localparam int K_BNE  = 2;
    localparam int K_ILL  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          EQ;
    logic          instr_req, IRWrite, ALUsrc, RegWrite, PCWrite, PCsrc, trap;
    logic [2:0]    ALUctrl;
    logic [1:0]    ImmSrc;
    logic [CW-1:0] retire_cnt;

    multicycle_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .EQ(EQ), .instr_req(instr_req), .IRWrite(IRWrite), .ALUsrc(ALUsrc),
        .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .PCsrc(PCsrc), .retire_cnt(retire_cnt), .trap(trap)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic        eq;
        int unsigned cyc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int unsigned   model_cnt = 0;
    int            exp_gap = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [11:0] all_outs();
        return {instr_req, IRWrite, ALUsrc, ALUctrl, ImmSrc, RegWrite, PCWrite, PCsrc, trap};
    endfunction

    // Monitor: invariants every cycle, scoreboard pop on every PCWrite pulse
    logic [7:0]    prev_s = '0;
    logic          cnt_pending = 1'b0;
    logic [CW-1:0] cnt_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_pending = 1'b0;
            prev_s      = '0;
        end else begin
            if (cnt_pending) begin
                check("retire_cnt", 32'(retire_cnt), 32'(cnt_exp));
                cnt_pending = 1'b0;
            end
            check("irwrite_rule", 32'(IRWrite), 32'(instr_req & instr_valid));
            check("regwrite_only_with_pcwrite", 32'(RegWrite & ~PCWrite), 32'd0);
            if (trap)
                check("trap_quiet", {28'd0, instr_req, IRWrite, RegWrite, PCWrite}, 32'd0);
            if (PCWrite) begin
                if (q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    logic [7:0] ecur, eprev;
                    logic       is_addi;
                    e = q.pop_front();
                    is_addi = (e.kind == K_ADDI);
                    if (e.kind == K_BNE) begin
                        // BRANCH, preceded by DECODE showing the B-type immediate
                        ecur  = {1'b0, ~e.eq, 1'b0, 3'b001, 2'b01};
                        eprev = {1'b0, 1'b0, 1'b0, 3'b000, 2'b01};
                    end else begin
                        // WB, preceded by EXEC with the same operand select
                        ecur  = {1'b1, 1'b0, is_addi, 3'b000, 2'b00};
                        eprev = {1'b0, 1'b0, is_addi, 3'b000, 2'b00};
                    end
                    check("retire_cycle", e.cyc, cyc);
                    check("retire_ctrl", 32'({RegWrite, PCsrc, ALUsrc, ALUctrl, ImmSrc}), 32'(ecur));
                    check("prior_ctrl", 32'(prev_s), 32'(eprev));
                    cnt_exp     = e.cnt;
                    cnt_pending = 1'b1;
                end
            end
            prev_s = {RegWrite, PCWrite, ALUsrc, ALUctrl, ImmSrc};
        end
    end

    function automatic logic [31:0] gen_word(input int kind);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        case (kind)
            K_ADDI:  return {imm, rs1, 3'b000, rd, 7'b0010011};
            K_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            default: return {imm[11:5], rs2, rs1, 3'b001, rd, 7'b1100011};
        endcase
    endfunction

    // Offer one instruction at the next FETCH; junk is driven while not requested.
    task automatic issue(input logic [31:0] w, input int kind, input logic eq, input int stall);
        int cnt;
        exp_t e;
        cnt = 0;
        while (!instr_req && cnt < 50) begin
            instr_valid = 1'($urandom);
            instr       = $urandom;
            @(posedge clk); #1;
            cnt++;
        end
        if (!instr_req) begin
            check("fetch_timeout", 32'd1, 32'd0);
            return;
        end
        if (exp_gap >= 0)
            check("fetch_gap", cnt, exp_gap);
        for (int i = 0; i < stall; i++) begin
            instr_valid = 1'b0;
            @(posedge clk); #1;
            check("stall", {29'd0, instr_req, IRWrite, PCWrite | RegWrite}, 32'd4);
        end
        instr       = w;
        instr_valid = 1'b1;
        EQ          = eq;
        #1 check("irwrite_on_accept", 32'(IRWrite), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (kind == K_ILL) begin
            exp_gap = -1;
        end else begin
            model_cnt = (model_cnt + 1) % (1 << CW);
            e.kind = kind;
            e.eq   = eq;
            e.cyc  = cyc + ((kind == K_BNE) ? 1 : 2);
            e.cnt  = CW'(model_cnt);
            q.push_back(e);
            exp_gap = (kind == K_BNE) ? 2 : 3;
        end
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (q.size() > 0 && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        @(posedge clk); #1;
        exp_gap = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        model_cnt = 0;
        exp_gap   = -1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_after_release", 32'(all_outs()), 32'd0);
        @(posedge clk); #1;
        check("first_req", 32'(instr_req), 32'd1);
    endtask

    initial begin
        logic [31:0] ill[4];
        int          k;
        ill[0] = 32'h00000000;
        ill[1] = 32'h402081B3;
        ill[2] = 32'h00208463;
        ill[3] = 32'h00109093;

        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; EQ = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outs", 32'(all_outs()), 32'd0);
        check("reset_cnt", 32'(retire_cnt), 32'd0);

        // Release with a valid word already present: IDLE must ignore it
        @(negedge clk);
        instr = 32'h00500093; instr_valid = 1'b1; rst_n = 1'b1;
        #1 check("idle_ignores_valid", {30'd0, instr_req, IRWrite}, 32'd0);
        @(posedge clk); #1;
        check("first_fetch_irwrite", {30'd0, instr_req, IRWrite}, 32'd3);
        issue(32'h00500093, K_ADDI, 1'b0, 0);
        issue(32'h002081B3, K_ADD,  1'b0, 0);
        issue(32'h00209463, K_BNE,  1'b0, 0);
        issue(32'h00209463, K_BNE,  1'b1, 0);
        issue(32'h002081B3, K_ADD,  1'b1, 5);
        drain();
        check("cnt_after_directed", 32'(retire_cnt), 32'd5);

        // Reset in the middle of EXEC
        issue(32'h002081B3, K_ADD, 1'b0, 0);
        @(posedge clk); #1;
        do_reset();
        check("midexec_reset_outs", 32'(all_outs()), 32'd0);
        check("midexec_reset_cnt", 32'(retire_cnt), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("held_reset_outs", 32'(all_outs()), 32'd0);
        end
        release_reset();

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 16; i++) issue(gen_word(K_ADDI), K_ADDI, 1'($urandom), 0);
        drain();
        check("cnt_wrap", 32'(retire_cnt), 32'd0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            issue(gen_word(k), k, 1'($urandom), $urandom_range(0, 2));
        end
        drain();

        for (int n = 0; n < 4; n++) begin
            issue(ill[n], K_ILL, 1'b0, 0);
            @(posedge clk); #1;
            check("trap_set", 32'(trap), 32'd1);
            for (int i = 0; i < 20; i++) begin
                instr_valid = 1'b1;
                instr       = (i % 2 == 0) ? 32'h00500093 : $urandom;
                @(posedge clk); #1;
                check("trap_hold", {30'd0, instr_req, trap}, 32'd1);
                check("trap_cnt", 32'(retire_cnt), model_cnt);
            end
            instr_valid = 1'b0;
            do_reset();
            check("trap_cleared", 32'(trap), 32'd0);
            release_reset();
            issue(gen_word(K_ADDI), K_ADDI, 1'b0, 0);
            drain();
        end

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the reduced RISC-V core. It fetches one instruction at a time over a valid handshake, decodes addi/add/bne, and steps the shared datapath through execute and writeback. It drives the ALU operand-select (ALUsrc), ALU operation, immediate format, register write and PC update strobes. It sits between instruction memory and the datapath, replacing the single-cycle combinational control decode.

## Interface
- DATA_WIDTH, 32, instruction width
- CNT_WIDTH, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr  in  DATA_WIDTH  instruction word from instruction memory
- instr_valid  in  1  instr is valid this cycle
- EQ  in  1  ALU equality flag (operands equal)
- instr_req  out  1  request next instruction
- IRWrite  out  1  load instruction register
- ALUsrc  out  1  ALU operand 2 select: 1 = ImmOp, 0 = regOp2
- ALUctrl  out  3  000 = add, 001 = sub
- ImmSrc  out  2  00 = I-type, 01 = B-type
- RegWrite  out  1  register file write enable
- PCWrite  out  1  PC update strobe
- PCsrc  out  1  0 = PC+4, 1 = PC+branch immediate
- retire_cnt  out  CNT_WIDTH  instructions retired, wraps
- trap  out  1  illegal instruction seen; core halted

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, BRANCH, TRAP.
- Reset (rst_n low, immediately): state = IDLE, latched class = NONE, retire_cnt = 0. All outputs 0.
- IDLE: all outputs 0; unconditionally -> FETCH.
- FETCH: instr_req = 1. When instr_valid = 1: IRWrite = 1 (same cycle), latch decode of instr, -> DECODE. Else stay. instr_valid is ignored in all other states.
- Decode (on latched word): opcode 0010011 & funct3 000 -> ADDI; opcode 0110011 & funct3 000 & funct7 0000000 -> ADD; opcode 1100011 & funct3 001 -> BNE; anything else -> ILLEGAL.
- DECODE: ImmSrc driven from class (ADDI 00, BNE 01, ADD 00). ADDI/ADD -> EXEC; BNE -> BRANCH; ILLEGAL -> TRAP.
- EXEC: ALUctrl = 000; ALUsrc = 1 for ADDI, 0 for ADD. -> WB.
- WB: same ALUsrc/ALUctrl as EXEC (operand stable); RegWrite = 1, PCWrite = 1, PCsrc = 0; retire_cnt += 1. -> FETCH.
- BRANCH: ALUsrc = 0, ALUctrl = 001, ImmSrc = 01, PCWrite = 1, PCsrc = ~EQ (combinational from EQ); retire_cnt += 1. -> FETCH.
- TRAP: trap = 1, all strobes 0; state held until reset.
- Outputs not listed for a state are 0 (Moore, except PCsrc in BRANCH).
- retire_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Timing
- Strobes asserted exactly one cycle per state visit; RegWrite and PCWrite never both high outside WB.
- Latency from instr_valid accept edge: ADDI/ADD retire 3 cycles later (DECODE, EXEC, WB); BNE retires 2 cycles later (DECODE, BRANCH).
- Back-to-back throughput: 4 cycles per ALU instruction, 3 per branch with instr_valid held high.
- First instr_req rises one cycle after rst_n deasserts.
- Reset mid-instruction: WB/BRANCH side effects suppressed; no RegWrite/PCWrite pulse; restart from IDLE.
- instr_valid high in FETCH on the same edge as reset release: ignored (state is IDLE).

## Test plan
- Reset: rst_n low mid-EXEC -> all outputs 0 immediately, retire_cnt 0; after release, IDLE 1 cycle then instr_req = 1.
- addi x1,x0,5 (0x00500093), valid in first FETCH cycle -> IRWrite that cycle; EXEC ALUsrc = 1, ALUctrl 000; WB RegWrite = PCWrite = 1, PCsrc 0; retire_cnt = 1.
- add x3,x1,x2 (0x002081B3) -> ALUsrc = 0 in EXEC and WB; RegWrite pulse 1 cycle; 4 cycles valid-to-valid.
- bne x1,x2,8 (0x00209463) with EQ = 0 -> BRANCH PCWrite = 1, PCsrc = 1, ALUctrl 001, no RegWrite; repeat with EQ = 1 -> PCsrc = 0.
- Illegal word 0x00000000 -> TRAP, trap = 1, instr_req stays 0 for 20 cycles despite instr_valid = 1; retire_cnt unchanged.
- FETCH stall: instr_valid low 5 cycles -> instr_req held high, no other strobes; CNT_WIDTH = 4 with 16 addi -> retire_cnt wraps to 0.
